// File: rtl/ring_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency counter.
// Holds the measurement FSM state encoding and the timer-width helper.
package ring_meas_pkg;

  localparam int DEF_GATE_CYCLES   = 133000;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_COUNT_W       = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meas_state_e;

  // The single down-counter serves both phases, so it must hold the larger reload value.
  function automatic int timer_width(input int gate, input int settle);
    int m;
    m = (gate > settle) ? gate : settle;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ring_freq_counter_if.sv
// Control/result bundle between a measurement requester and ring_freq_counter.
interface ring_freq_counter_if
  import ring_meas_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
);
  logic               start;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] count;
  logic               overflow;

  modport master (output start, input busy, input done, input count, input overflow);
  modport slave  (input start, output busy, output done, output count, output overflow);
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus edge register for the free-running ring oscillator.
// rise_pulse is high for one cycle per synchronized rising edge of async_in.
module sync_edge_detect (
  input  logic fpga_clock,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  // [0] and [1] form the synchronizer, [2] holds the previous synchronized level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge fpga_clock) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ring_freq_counter.sv
// Gated edge counter for an on-chip ring oscillator: enable, settle, count for a
// fixed window, then publish the saturated count and an overflow flag.
module ring_freq_counter
  import ring_meas_pkg::*;
#(
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int COUNT_W       = DEF_COUNT_W
) (
  input  logic                fpga_clock,
  input  logic                reset_n,
  input  logic                ring_in,
  output logic                ring_en,
  ring_freq_counter_if.slave  bus
);

  localparam int TW = timer_width(GATE_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);

  meas_state_e        state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               ring_en_q, ring_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rise_pulse;

  sync_edge_detect u_sync (
    .fpga_clock (fpga_clock),
    .reset_n    (reset_n),
    .async_in   (ring_in),
    .rise_pulse (rise_pulse)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    ovf_flag_d = ovf_flag_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETTLE;
          timer_d = SETTLE_LAST;
        end
      end
      ST_SETTLE: begin
        edge_cnt_d = '0;
        ovf_flag_d = 1'b0;
        if (timer_q == '0) begin
          state_d = ST_MEASURE;
          timer_d = GATE_LAST;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_MEASURE: begin
        if (rise_pulse) begin
          if (edge_cnt_q == '1) begin
            ovf_flag_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + COUNT_W'(1);
          end
        end
        // Publish on entry to DONE so count is already valid while done is high.
        if (timer_q == '0) begin
          state_d    = ST_DONE;
          count_d    = edge_cnt_d;
          overflow_d = ovf_flag_d;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ring_en_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge fpga_clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      ovf_flag_q <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ring_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_flag_q <= ovf_flag_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ring_en_q  <= ring_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ring_en      = ring_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ring_freq_counter.sv
// Directed bench for ring_freq_counter: two instances (8-bit and 4-bit counters)
// with behavioural ring oscillators and a per-instance expected-result queue.
module tb_ring_freq_counter;

  typedef struct {
    int cnt;
    int ovf;
  } exp_t;

  logic clk;
  logic reset_n;
  logic ring_a, ring_b;
  logic ring_en_a, ring_en_b;

  int   compared   = 0;
  int   mismatched = 0;
  int   half_a = 5, half_b = 2;
  int   ph_a = 0, ph_b = 0;
  bit   free_a = 1'b0;
  int   done_cnt_a = 0, done_cnt_b = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  ring_freq_counter_if #(.COUNT_W(8)) bus_a ();
  ring_freq_counter_if #(.COUNT_W(4)) bus_b ();

  ring_freq_counter #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_W(8)) dut_a (
    .fpga_clock (clk),
    .reset_n    (reset_n),
    .ring_in    (ring_a),
    .ring_en    (ring_en_a),
    .bus        (bus_a.slave)
  );

  ring_freq_counter #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .COUNT_W(4)) dut_b (
    .fpga_clock (clk),
    .reset_n    (reset_n),
    .ring_in    (ring_b),
    .ring_en    (ring_en_b),
    .bus        (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ring oscillators: toggle every half_x cycles while enabled; half_x == 0 holds the level.
  initial begin
    ring_a = 1'b0;
    forever begin
      @(negedge clk);
      if ((ring_en_a === 1'b1 || free_a) && half_a > 0) begin
        ph_a++;
        if (ph_a >= half_a) begin
          ph_a   = 0;
          ring_a = ~ring_a;
        end
      end
    end
  end

  initial begin
    ring_b = 1'b0;
    forever begin
      @(negedge clk);
      if (ring_en_b === 1'b1 && half_b > 0) begin
        ph_b++;
        if (ph_b >= half_b) begin
          ph_b   = 0;
          ring_b = ~ring_b;
        end
      end
    end
  end

  // Result monitors: every done pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_a.done === 1'b1) begin
        done_cnt_a++;
        check("a_done_expected", 32'(exp_a.size() != 0), 32'd1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("a_count", 32'(bus_a.count), e.cnt);
          check("a_overflow", 32'(bus_a.overflow), e.ovf);
          $display("run A: count=%0d overflow=%0d (exp %0d/%0d)", bus_a.count, bus_a.overflow, e.cnt, e.ovf);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_b.done === 1'b1) begin
        done_cnt_b++;
        check("b_done_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("b_count", 32'(bus_b.count), e.cnt);
          check("b_overflow", 32'(bus_b.overflow), e.ovf);
          $display("run B: count=%0d overflow=%0d (exp %0d/%0d)", bus_b.count, bus_b.overflow, e.cnt, e.ovf);
        end
      end
    end
  end

  // Counts negedges until done is seen; -1 if the budget expires.
  task automatic wait_done(input bit use_b, output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if ((use_b ? bus_b.done : bus_a.done) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic pulse_start(input bit use_b);
    if (use_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(negedge clk);
    if (use_b) bus_b.start = 1'b0; else bus_a.start = 1'b0;
  endtask

  initial begin
    int n;
    int snap;
    reset_n     = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ring_en", 32'(ring_en_a), 0);
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_done", 32'(bus_a.done), 0);
    check("rst_count", 32'(bus_a.count), 0);
    check("rst_overflow", 32'(bus_a.overflow), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic timing: busy one cycle after start, done 105 cycles after start.
    exp_a.push_back('{10, 0});
    pulse_start(1'b0);
    check("basic_busy", 32'(bus_a.busy), 1);
    check("basic_ring_en", 32'(ring_en_a), 1);
    wait_done(1'b0, n);
    check("basic_latency", n, 104);
    check("basic_ring_en_at_done", 32'(ring_en_a), 0);
    @(negedge clk);
    check("basic_busy_after", 32'(bus_a.busy), 0);
    check("basic_done_one_cycle", 32'(bus_a.done), 0);

    // Static ring.
    half_a = 0;
    repeat (10) @(negedge clk);
    exp_a.push_back('{0, 0});
    pulse_start(1'b0);
    wait_done(1'b0, n);
    check("static_latency", n, 104);
    half_a = 5;
    repeat (5) @(negedge clk);

    // Overflow on the 4-bit instance, then recovery at a slower ring.
    exp_b.push_back('{15, 1});
    pulse_start(1'b1);
    wait_done(1'b1, n);
    check("ovf_latency", n, 104);
    half_b = 5;
    repeat (5) @(negedge clk);
    exp_b.push_back('{10, 0});
    pulse_start(1'b1);
    wait_done(1'b1, n);
    check("ovf_recover_latency", n, 104);

    // Retrigger with start held high.
    repeat (5) @(negedge clk);
    repeat (3) exp_a.push_back('{10, 0});
    bus_a.start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, n);
    check("retrig_first", n, 104);
    wait_done(1'b0, n);
    check("retrig_gap1", n, 106);
    wait_done(1'b0, n);
    check("retrig_gap2", n, 106);
    bus_a.start = 1'b0;
    snap = done_cnt_a;
    repeat (150) @(negedge clk);
    check("retrig_no_extra", done_cnt_a, snap);

    // Start pulses during busy are ignored.
    exp_a.push_back('{10, 0});
    pulse_start(1'b0);
    repeat (30) @(negedge clk);
    pulse_start(1'b0);
    repeat (30) @(negedge clk);
    pulse_start(1'b0);
    wait_done(1'b0, n);
    check("busy_start_done_seen", 32'(n > 0), 1);
    snap = done_cnt_a;
    repeat (150) @(negedge clk);
    check("busy_start_no_extra", done_cnt_a, snap);

    // Reset in the middle of MEASURE.
    pulse_start(1'b0);
    repeat (48) @(negedge clk);
    check("mid_rst_pre_busy", 32'(bus_a.busy), 1);
    snap = done_cnt_a;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_ring_en", 32'(ring_en_a), 0);
    check("mid_rst_busy", 32'(bus_a.busy), 0);
    check("mid_rst_count", 32'(bus_a.count), 0);
    check("mid_rst_overflow", 32'(bus_a.overflow), 0);
    check("mid_rst_b_count", 32'(bus_b.count), 0);
    repeat (150) @(negedge clk);
    check("mid_rst_no_done", done_cnt_a, snap);

    // Hold: result stays put while the ring keeps toggling in IDLE.
    exp_a.push_back('{10, 0});
    pulse_start(1'b0);
    wait_done(1'b0, n);
    check("hold_latency", n, 104);
    free_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("hold_count", 32'(bus_a.count), 10);
    end
    free_a = 1'b0;
    check("hold_idle_busy", 32'(bus_a.busy), 0);

    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ring_freq_counter.md
RING_FREQ_COUNTER -- requirements
Module: ring_freq_counter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 133000, meaning measurement window length in fpga_clock cycles (1 ms at 133 MHz).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, meaning cycles the ring runs before counting starts; legal range >= 4.
REQ-003 SHALL have parameter COUNT_W, default 24, meaning edge-counter and result width.
REQ-004 fpga_clock  in  1  sole clock; all logic on its rising edge (internal OSCH output).
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request one measurement; sampled only in IDLE.
REQ-007 ring_in  in  1  asynchronous ring oscillator output (and_1 of the oscillator).
REQ-008 ring_en  out  1  drives the oscillator en input.
REQ-009 busy  out  1  high in SETTLE, MEASURE and DONE.
REQ-010 done  out  1  one-cycle pulse when count is updated.
REQ-011 count  out  COUNT_W  rising edges of ring_in seen in the last completed window.
REQ-012 overflow  out  1  last window saturated the counter.

Function
REQ-013 ring_in SHALL pass through a 2-FF synchronizer plus one edge register; the rising-edge pulse (sync2 & ~sync3) SHALL be 3 cycles behind ring_in. The chain runs in all states.
REQ-014 FSM states SHALL be IDLE, SETTLE, MEASURE, DONE.
REQ-015 IDLE: ring_en=0, busy=0; start=1 -> SETTLE next cycle; start=0 -> stay.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles with ring_en=1; edges ignored; edge counter and overflow flag cleared; then -> MEASURE.
REQ-017 MEASURE SHALL last exactly GATE_CYCLES cycles with ring_en=1; each cycle with an edge pulse increments the edge counter by 1.
REQ-018 Edge counter SHALL saturate at 2^COUNT_W-1; an edge arriving at saturation sets the internal overflow flag.
REQ-019 DONE SHALL last exactly 1 cycle: ring_en=0, done=1, count<=edge counter, overflow<=flag; then -> IDLE.
REQ-020 count and overflow SHALL hold their values until the next DONE.
REQ-021 start asserted outside IDLE SHALL be ignored, not queued; start held high SHALL retrigger from the following IDLE cycle.
REQ-022 Inputs faster than fpga_clock/2 alias and are not flagged; the measurable range is f_ring < fpga_clock/2.
REQ-023 ring_en, busy and done SHALL be registered outputs decoded from state.

Reset
REQ-024 reset_n=0 at a clock edge SHALL force IDLE, ring_en=0, busy=0, done=0, count=0, overflow=0, and clear the edge counter, timers and synchronizer, from any state including mid-MEASURE.
REQ-025 After reset release, the first start SHALL be accepted on the first cycle in which it is sampled high.

Structure
REQ-026 Package ring_meas_pkg SHALL hold the state enum and the default GATE_CYCLES, SETTLE_CYCLES and COUNT_W constants.
REQ-027 The synchronizer and edge detector SHALL be a sub-module sync_edge_detect (ports fpga_clock, reset_n, async_in, rise_pulse).
REQ-028 The main FSM, cycle timer and saturating counter SHALL reside in ring_freq_counter.

Verification (GATE_CYCLES=100, SETTLE_CYCLES=4, COUNT_W=8; ring model toggles every 5 cycles while ring_en=1)
REQ-029 Basic: start for 1 cycle at t -> busy at t+1, done pulse at t+105, count=10, overflow=0, ring_en low from t+105.
REQ-030 Static ring: ring_in held 0 -> count=0, overflow=0 at done.
REQ-031 Overflow: COUNT_W=4, ring toggling every 2 cycles -> count=15, overflow=1; next run at a 10-cycle period -> count=10, overflow=0.
REQ-032 Retrigger: start held high -> done pulses exactly 106 cycles apart, each count=10; start pulses during busy produce no extra done.
REQ-033 Reset mid-MEASURE: reset_n=0 for 1 cycle at t+50 -> next cycle IDLE, ring_en=0, count=0, no done pulse.
REQ-034 Hold: after a done, count stays unchanged for 200 idle cycles with ring_in toggling.
